// File: rtl/my_tstamp_delta.sv
// my_tstamp_delta: elapsed-cycle measurement against the cnt32 free-running
// counter, wrapped in the ivalid/iready/ovalid/oready stall handshake.
//
// A START command stores the current counter value. A LAP or STOP command
// returns counter - start (mod 2^WIDTH), and STOP also disarms. Every
// accepted command pushes exactly one result into a DEPTH-entry output FIFO,
// so downstream back-pressure stalls the input instead of dropping results.
//
// Optional feature: define MY_TSTAMP_MAX_EN to track the largest LAP/STOP
// delta. Opcode 3 then returns that maximum; without the macro it returns
// the all-ones error sentinel.
//
// Ports:
//   clock    kernel clock, shared with the counter source
//   reset    synchronous, active-high reset
//   ivalid   upstream command valid
//   oready   command accepted this cycle if ivalid is also high
//   counter  timestamp from cnt32, sampled in the accept cycle
//   cmd      bits[1:0] opcode: 0=START 1=STOP 2=LAP 3=MAX/reserved
//   ovalid   output FIFO non-empty
//   iready   downstream takes the head result this cycle
//   result   head of the output FIFO, zero when empty
module my_tstamp_delta #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ivalid,
  input  logic             iready,
  output logic             ovalid,
  output logic             oready,
  input  logic [WIDTH-1:0] counter,
  input  logic [31:0]      cmd,
  output logic [WIDTH-1:0] result
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    RUNNING
  } state_t;

  // Unsigned subtract; the mod-2^WIDTH wrap of the counter cancels out.
  function automatic logic [WIDTH-1:0] wrap_delta(input logic [WIDTH-1:0] now,
                                                  input logic [WIDTH-1:0] mark);
    return now - mark;
  endfunction

  // Pointer increment that also works when DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   start_ts_q, start_ts_d;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   fifo_q [DEPTH];

  logic               accept, pop, push, push_delta;
  logic [WIDTH-1:0]   push_data, delta;
  logic               cmd_unused;

  assign cmd_unused = ^cmd[31:2];

  // The input is stalled while the FIFO is full, even if a pop happens in
  // the same cycle; this keeps oready a pure function of registered state.
  assign oready = !reset && (count_q < DEPTH_C);
  assign ovalid = (count_q != '0);
  assign result = ovalid ? fifo_q[rd_ptr_q] : '0;
  assign accept = ivalid && oready;
  assign pop    = ovalid && iready;
  assign delta  = wrap_delta(counter, start_ts_q);

`ifdef MY_TSTAMP_MAX_EN
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (push_delta && (delta > max_q)) max_d = delta;
  end

  always_ff @(posedge clock) begin
    if (reset) max_q <= '0;
    else       max_q <= max_d;
  end
`endif

  // Command decode: exactly one push per accepted command.
  always_comb begin
    state_d    = state_q;
    start_ts_d = start_ts_q;
    push       = 1'b0;
    push_delta = 1'b0;
    push_data  = '1;
    if (accept) begin
      push = 1'b1;
      unique case (cmd[1:0])
        2'd0: begin
          start_ts_d = counter;
          push_data  = '0;
          state_d    = RUNNING;
        end
        2'd1, 2'd2: begin
          if (state_q == RUNNING) begin
            push_data  = delta;
            push_delta = 1'b1;
            if (cmd[1:0] == 2'd1) state_d = IDLE;
          end
        end
        default: begin
`ifdef MY_TSTAMP_MAX_EN
          push_data = max_q;
`else
          push_data = '1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      start_ts_q <= '0;
    end else begin
      state_q    <= state_d;
      start_ts_q <= start_ts_d;
    end
  end

  // Output FIFO: control is reset, storage is not (result is masked to 0
  // while empty).
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_my_tstamp_delta.sv
module tb_my_tstamp_delta;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ivalid = 1'b0;
  logic        iready;
  logic        ovalid, oready;
  logic [31:0] counter = '0;
  logic [31:0] cmd = '0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  logic [31:0] expq[$];

  // Reference model state
  bit          m_running = 0;
  logic [31:0] m_start = '0;
  logic [31:0] m_max = '0;

  my_tstamp_delta #(.WIDTH(32), .DEPTH(2)) dut (
    .clock(clk), .reset(reset), .ivalid(ivalid), .iready(iready),
    .ovalid(ovalid), .oready(oready), .counter(counter), .cmd(cmd),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready driver
  initial begin
    iready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       iready = 1'b0;
        1:       iready = 1'b1;
        default: iready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares the FIFO head against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ovalid) begin
          if (expq.size() == 0) begin
            check("unexpected_ovalid", 32'd1, 32'd0);
          end else begin
            check("result", result, expq[0]);
            if (iready) void'(expq.pop_front());
          end
        end else begin
          check("empty_result_zero", result, 32'd0);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] cv);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    case (op)
      2'd0: begin r = 0; m_running = 1; m_start = cv; end
      2'd1, 2'd2: begin
        if (m_running) begin
          r = cv - m_start;
          if (r > m_max) m_max = r;
          if (op == 2'd1) m_running = 0;
        end
      end
      default: begin
`ifdef MY_TSTAMP_MAX_EN
        r = m_max;
`else
        r = 32'hFFFF_FFFF;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] cv);
    bit done;
    done = 0;
    @(posedge clk); #1;
    ivalid  = 1'b1;
    cmd     = ($urandom() & 32'hFFFF_FFFC) | {30'd0, op};
    counter = cv;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (oready) begin
        expq.push_back(model(op, cv));
        done = 1;
      end
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    counter = $urandom();
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      check("ovalid_after_accept", {31'd0, ovalid}, 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || ovalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", expq.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ivalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expq.delete();
    m_running = 0; m_start = 0; m_max = 0;
    @(negedge clk);
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_oready", {31'd0, oready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_oready", {31'd0, oready}, 32'd1);
    check("post_rst_ovalid", {31'd0, ovalid}, 32'd0);
  endtask

  initial begin
    do_reset();

    // Basic interval
    ready_mode = 1;
    issue(2'd0, 32'd100);
    issue(2'd1, 32'd150);
    drain();

    // Counter wrap
    issue(2'd0, 32'hFFFF_FFF0);
    issue(2'd2, 32'h0000_0005);
    issue(2'd1, 32'h0000_0010);
    drain();

    // Commands while idle give the error sentinel
    issue(2'd1, 32'd77);
    issue(2'd2, 32'd88);
    drain();

    // Back-pressure: third command held until downstream drains
    ready_mode = 0;
    repeat (2) @(posedge clk);
    issue(2'd0, 32'd10);
    issue(2'd2, 32'd20);
    @(negedge clk);
    check("full_oready_low", {31'd0, oready}, 32'd0);
    fork
      issue(2'd2, 32'd35);
    join_none
    repeat (4) @(negedge clk);
    check("held_oready_low", {31'd0, oready}, 32'd0);
    check("held_queue_depth", expq.size(), 32'd2);
    ready_mode = 1;
    wait fork;
    drain();

    // Max tracking (deltas 40, 90, 30 then opcode 3)
    issue(2'd0, 32'd1000);
    issue(2'd1, 32'd1040);
    issue(2'd0, 32'd2000);
    issue(2'd1, 32'd2090);
    issue(2'd0, 32'd3000);
    issue(2'd2, 32'd3030);
    issue(2'd3, 32'd4000);
    drain();

    // Randomized traffic with random downstream stalls
    ready_mode = 2;
    for (int k = 0; k < 400; k++) begin
      issue(2'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    ready_mode = 1;
    drain();

    // Mid-operation reset discards queued results and the armed start
    ready_mode = 0;
    issue(2'd0, 32'd5);
    issue(2'd2, 32'd9);
    do_reset();
    ready_mode = 1;
    issue(2'd2, 32'd50);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_tstamp_delta.md
Name: my_tstamp_delta

Overview:
- Downstream consumer of the cnt32 free-running cycle counter.
- Packaged as an OpenCL library function with the standard ivalid/iready/ovalid/oready stall-based handshake.
- Each accepted command samples the counter and returns elapsed cycles since the last start mark, with mod-2^32 wrap handling.
- Results are queued in a small output FIFO so downstream back-pressure never drops a measurement.

Parameters:
- WIDTH, 32, timestamp/result width; must equal the counter width.
- DEPTH, 2, output FIFO entries (>=1).

Ports:
- clock  in  1  kernel clock; same clock as the counter source.
- reset  in  1  synchronous, active-high reset.
- ivalid  in  1  upstream command valid.
- iready  in  1  downstream ready to take result.
- ovalid  out  1  result valid (FIFO non-empty).
- oready  out  1  block can accept a command.
- counter  in  WIDTH  timestamp from cnt32.
- cmd  in  32  bits[1:0] opcode: 0=START, 1=STOP, 2=LAP, 3=reserved/optional; bits[31:2] ignored.
- result  out  WIDTH  head of output FIFO.

Behaviour:
- Accept: ivalid && oready at a rising edge. Output transfer: ovalid && iready at a rising edge.
- oready = !reset && (fifo_count < DEPTH); combinational from registered count. No same-cycle bypass: a full FIFO blocks input even if a pop occurs that cycle.
- Reset (sync, high) forces: state=IDLE, start_ts=0, fifo_count=0, ovalid=0, result=0, oready=0. Mid-operation reset discards queued results and any armed start.
- FSM, two states:
  - IDLE, START: start_ts<=counter; push 0; ->RUNNING.
  - IDLE, STOP or LAP: push all-ones (error sentinel); stay IDLE.
  - RUNNING, START: re-arm, start_ts<=counter; push 0; stay RUNNING.
  - RUNNING, LAP: push counter-start_ts; stay RUNNING.
  - RUNNING, STOP: push counter-start_ts; ->IDLE.
- Opcode 3 without the optional feature: push all-ones, no state change.
- Delta is an unsigned WIDTH-bit subtract, wrap-safe for intervals < 2^WIDTH. counter is sampled in the accept cycle.
- Latency: accepted at edge N, so the result is visible with ovalid=1 after edge N (next cycle) when the FIFO was empty; otherwise it follows FIFO order.
- Simultaneous push and pop: count unchanged, order preserved.
- result holds its value while ovalid && !iready; result=0 when empty.
- Unaccepted cycles (ivalid=0 or oready=0) cause no state change.

Optional Feature:
- Macro: MY_TSTAMP_MAX_EN.
- Defined:
  - Adds register max_delta (reset 0), updated on every LAP/STOP delta push to max(max_delta, delta).
  - Opcode 3 pushes max_delta with no FSM change.
  - START does not clear max_delta; only reset clears it.
- Undefined:
  - No max register.
  - Opcode 3 pushes all-ones.

Test Plan:
- Reset then idle -> ovalid=0, result=0, oready=0 during reset and 1 on the first cycle after.
- START at counter=100, STOP at counter=150, iready=1 -> results 0 then 50; each ovalid one cycle after accept.
- START at 0xFFFFFFF0, LAP at 0x00000005, STOP at 0x00000010 -> 0, 0x15, 0x20.
- STOP in IDLE -> 0xFFFFFFFF, state stays IDLE; a following LAP also gives 0xFFFFFFFF.
- iready=0, issue 3 commands back-to-back (DEPTH=2) -> oready drops after 2 accepts, the third is held. Raise iready -> all 3 results drain in order, none lost.
- MY_TSTAMP_MAX_EN: deltas 40, 90, 30, then opcode 3 -> 90. Without the macro, opcode 3 -> 0xFFFFFFFF.
